apb_slave_mem: RTL and testbench

- APB4 completer (slave) that responds to transfers driven on the team's APB interface.
- Backed by a word-addressed register memory.
- Programmable wait states; error response for misaligned, out-of-range and (optionally) protection-violating accesses.
- Serves as the DUT end of the APB UVM environment, which drives the master side.

---
 rtl/apb_slave_mem.sv | 164 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word-addressed register memory with programmable wait states.
// Optional build macro APB_SLV_PROT_EN: unprivileged writes at or above word PROT_BASE are rejected.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0,
  parameter int PROT_BASE   = 32
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH*4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    err_q, err_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic                    mem_we;

  logic [IDX_W-1:0]        setup_idx;
  logic                    setup_err;
  logic                    prot_err;
  logic                    unused_prot;
  logic                    to_ready;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_err;
  logic                    rd_write;

  assign setup_idx = PADDR[IDX_W+1:2];

`ifdef APB_SLV_PROT_EN
  localparam logic [IDX_W:0] PROT_IDX = (IDX_W+1)'(PROT_BASE);
  assign prot_err    = PWRITE && !PPROT[0] && ({1'b0, setup_idx} >= PROT_IDX);
  assign unused_prot = ^PPROT[2:1];
`else
  assign prot_err    = 1'b0;
  assign unused_prot = ^PPROT;
`endif

  assign setup_err = (PADDR[1:0] != 2'b00) || ({1'b0, PADDR} >= MEM_BYTES) || prot_err;

  // Handshake: a setup phase is PSEL=1/PENABLE=0 seen in IDLE; the transfer completes on the
  // edge where PSEL, PENABLE and PREADY are all high; PSEL dropping earlier abandons it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_we    = 1'b0;
    to_ready  = 1'b0;
    rd_idx    = idx_q;
    rd_err    = err_q;
    rd_write  = write_q;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = setup_idx;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          err_d   = setup_err;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d  = S_READY;
            to_ready = 1'b1;
            rd_idx   = setup_idx;
            rd_err   = setup_err;
            rd_write = PWRITE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d  = S_READY;
            to_ready = 1'b1;
          end
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        mem_we  = PSEL && PENABLE && write_q && !err_q;
      end
      default: state_d = S_IDLE;
    endcase
    // Read data is captured on entry to READY so it reflects every earlier committed write.
    if (to_ready) begin
      pready_d  = 1'b1;
      pslverr_d = rd_err;
      if (!rd_write && !rd_err) prdata_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (mem_we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with no wait states, one with three.
module tb_apb_slave_mem;
  logic        clk;
  logic        rst;
  logic        psel0, psel3;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;
  logic        pslverr0, pslverr3;

  int total = 0;
  int bad   = 0;

`ifdef APB_SLV_PROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  apb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic cur_rdy(input int ws);
    return (ws == 0) ? pready0 : pready3;
  endfunction

  function automatic logic cur_err(input int ws);
    return (ws == 0) ? pslverr0 : pslverr3;
  endfunction

  function automatic logic [31:0] cur_rdata(input int ws);
    return (ws == 0) ? prdata0 : prdata3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the completion edge with the bus idle.
  task automatic xfer_chk(input string tag, input int ws, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic exp_err, input logic [31:0] exp_rdata);
    int          lat;
    logic        err_s;
    logic [31:0] rd_s;
    psel0   = (ws == 0);
    psel3   = (ws == 3);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = addr ^ 32'h4;
    pwdata  = ~wdata;
    lat     = 1;
    while (!cur_rdy(ws) && lat < 20) begin
      check({tag, "_wait_err"}, 32'(cur_err(ws)), 32'h0);
      check({tag, "_wait_rdata"}, cur_rdata(ws), 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    err_s = cur_err(ws);
    rd_s  = cur_rdata(ws);
    @(posedge clk); #1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(ws + 1));
    check({tag, "_err"}, 32'(err_s), 32'(exp_err));
    if (!wr) check({tag, "_rdata"}, rd_s, exp_rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_pready0", 32'(pready0), 32'h0);
    check("rst_pslverr0", 32'(pslverr0), 32'h0);
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_pready3", 32'(pready3), 32'h0);
    check("rst_pslverr3", 32'(pslverr3), 32'h0);
    check("rst_prdata3", prdata3, 32'h0);

    xfer_chk("w08", 0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer_chk("r08", 0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000, 1'b0, 32'hDEADBEEF);
    idle(1);
    xfer_chk("ws3_r10", 3, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0);

    xfer_chk("w04_full", 0, 1'b1, 32'h04, 32'h11223344, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer_chk("w04_part", 0, 1'b1, 32'h04, 32'hAABBCCDD, 4'h5, 3'b000, 1'b0, 32'h0);
    xfer_chk("r04", 0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'h11BB33DD);
    xfer_chk("w08_nostrb", 0, 1'b1, 32'h08, 32'h00000000, 4'h0, 3'b000, 1'b0, 32'h0);
    xfer_chk("r08_nostrb", 0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000, 1'b0, 32'hDEADBEEF);

    xfer_chk("w102", 0, 1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b1, 32'h0);
    xfer_chk("w100", 0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b1, 32'h0);
    xfer_chk("w0a", 0, 1'b1, 32'h0A, 32'h00000000, 4'hF, 3'b000, 1'b1, 32'h0);
    xfer_chk("r100", 0, 1'b0, 32'h100, 32'h0, 4'hF, 3'b000, 1'b1, 32'h0);
    xfer_chk("r00_after_err", 0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer_chk("r08_after_err", 0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000, 1'b0, 32'hDEADBEEF);

    // Access phase with no setup phase must be ignored.
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h0; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("nosetup_pready", 32'(pready0), 32'h0);
    end
    psel0 = 1'b0; penable = 1'b0;
    idle(1);
    xfer_chk("r08_nosetup", 0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000, 1'b0, 32'hDEADBEEF);

    // Back-to-back: the read setup follows the write completion with no idle cycle.
    xfer_chk("b2b_w0c", 0, 1'b1, 32'h0C, 32'h00000005, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer_chk("b2b_r0c", 0, 1'b0, 32'h0C, 32'h0, 4'hF, 3'b000, 1'b0, 32'h00000005);

    // Abort during WAIT on the three-wait-state instance.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("abw_pready_mid", 32'(pready3), 32'h0);
    psel3 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abw_pready_after", 32'(pready3), 32'h0);
    end
    xfer_chk("abw_r14", 3, 1'b0, 32'h14, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0);

    // Abort during READY on the zero-wait-state instance.
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h00000077; pstrb = 4'hF;
    @(posedge clk); #1;
    check("abr_pready_pre", 32'(pready0), 32'h1);
    psel0 = 1'b0;
    @(posedge clk); #1;
    check("abr_pready_post", 32'(pready0), 32'h0);
    check("abr_pslverr_post", 32'(pslverr0), 32'h0);
    xfer_chk("abr_r18", 0, 1'b0, 32'h18, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0);

    xfer_chk("ws3_w20", 3, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer_chk("ws3_r20", 3, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 1'b0, 32'hCAFEF00D);

    xfer_chk("prot_w80_user", 0, 1'b1, 32'h80, 32'hA5A5A5A5, 4'hF, 3'b000, PROT_ON, 32'h0);
    xfer_chk("prot_r80_user", 0, 1'b0, 32'h80, 32'h0, 4'hF, 3'b000, 1'b0,
             PROT_ON ? 32'h0 : 32'hA5A5A5A5);
    xfer_chk("prot_w80_priv", 0, 1'b1, 32'h80, 32'h3C3C3C3C, 4'hF, 3'b001, 1'b0, 32'h0);
    xfer_chk("prot_r80_priv", 0, 1'b0, 32'h80, 32'h0, 4'hF, 3'b000, 1'b0, 32'h3C3C3C3C);
    xfer_chk("prot_w7c_user", 0, 1'b1, 32'h7C, 32'h0BADF00D, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer_chk("prot_r7c", 0, 1'b0, 32'h7C, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0BADF00D);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
